// File: rtl/contador_monitor.sv
// On-chip checker for the counter stream: locks onto the sequence, predicts
// prev + STEP each sample, and counts/captures mismatches seen while locked.
module contador_monitor #(
  parameter int WIDTH    = 4,
  parameter int STEP     = 1,
  parameter int LOCK_CNT = 2,
  parameter int MAX_ERR  = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] contador,
  output logic             locked,
  output logic             diff_flag,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] first_err_got,
  output logic [WIDTH-1:0] first_err_exp,
  output logic             fail
);

  localparam int GR_W = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [GR_W-1:0]  LOCK_W   = GR_W'(LOCK_CNT);
  localparam logic [ERR_W-1:0] MAX_W    = ERR_W'(MAX_ERR);
  localparam logic [ERR_W-1:0] ERR_SAT  = '1;

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_LOCKING,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] prev, prev_n;
  logic [GR_W-1:0]  good_run, good_run_n, run_inc;
  logic [WIDTH-1:0] exp_val;
  logic             match;
  logic [ERR_W-1:0] err_inc;
  logic             locked_n, diff_n, fail_n;
  logic [ERR_W-1:0] err_n;
  logic [WIDTH-1:0] got_n, expc_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_UNLOCKED;
      prev          <= '0;
      good_run      <= '0;
      locked        <= 1'b0;
      diff_flag     <= 1'b0;
      err_count     <= '0;
      first_err_got <= '0;
      first_err_exp <= '0;
      fail          <= 1'b0;
    end else begin
      state         <= state_n;
      prev          <= prev_n;
      good_run      <= good_run_n;
      locked        <= locked_n;
      diff_flag     <= diff_n;
      err_count     <= err_n;
      first_err_got <= got_n;
      first_err_exp <= expc_n;
      fail          <= fail_n;
    end
  end

  always_comb begin
    exp_val    = prev + STEP_W;
    match      = (contador == exp_val);
    run_inc    = good_run + 1'b1;
    err_inc    = (err_count == ERR_SAT) ? err_count : err_count + 1'b1;
    state_n    = state;
    prev_n     = prev;
    good_run_n = good_run;
    locked_n   = locked;
    diff_n     = 1'b0;
    fail_n     = fail;
    err_n      = err_count;
    got_n      = first_err_got;
    expc_n     = first_err_exp;

    if (sample_en) begin
      case (state)
        ST_UNLOCKED: begin
          prev_n     = contador;
          good_run_n = '0;
          state_n    = ST_LOCKING;
        end
        ST_LOCKING: begin
          prev_n = contador;
          if (!match) begin
            good_run_n = '0;
          end else if (run_inc >= LOCK_W) begin
            good_run_n = '0;
            state_n    = ST_LOCKED;
            locked_n   = 1'b1;
          end else begin
            good_run_n = run_inc;
          end
        end
        ST_LOCKED: begin
          // Always follow the observed value so one glitch costs one error.
          prev_n = contador;
          if (!match) begin
            diff_n = 1'b1;
            err_n  = err_inc;
            if (err_count == '0) begin
              got_n  = contador;
              expc_n = exp_val;
            end
            if ((MAX_ERR != 0) && (err_inc >= MAX_W)) begin
              state_n  = ST_FAIL;
              locked_n = 1'b0;
              fail_n   = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_contador_monitor.sv
// Self-checking bench for contador_monitor: a behavioural model pushes the
// expected post-edge outputs to a scoreboard that is popped after each edge.
module tb_contador_monitor;

  logic       clock;
  logic       reset;
  logic       sample_en;
  logic [3:0] contador;
  logic       locked;
  logic       diff_flag;
  logic [7:0] err_count;
  logic [3:0] first_err_got;
  logic [3:0] first_err_exp;
  logic       fail;

  typedef struct {
    int locked;
    int diff;
    int err;
    int got;
    int expv;
    int fail;
  } exp_t;

  exp_t sb_q[$];
  int   check_count = 0;
  int   pass_count  = 0;
  int   cycle_count = 0;

  int m_state, m_prev, m_run, m_err, m_got, m_expv;
  int m_locked, m_diff, m_fail;

  contador_monitor #(
    .WIDTH(4), .STEP(1), .LOCK_CNT(2), .MAX_ERR(3), .ERR_W(8)
  ) dut (
    .clk(clock),
    .reset(reset),
    .sample_en(sample_en),
    .contador(contador),
    .locked(locked),
    .diff_flag(diff_flag),
    .err_count(err_count),
    .first_err_got(first_err_got),
    .first_err_exp(first_err_exp),
    .fail(fail)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Model states: 0 unlocked, 1 locking, 2 locked, 3 failed.
  task automatic modelStep(input int rst, input int en, input int value);
    int pred;
    m_diff = 0;
    if (rst != 0) begin
      m_state = 0; m_prev = 0; m_run = 0; m_err = 0;
      m_got = 0; m_expv = 0; m_locked = 0; m_fail = 0;
    end else if (en != 0) begin
      pred = (m_prev + 1) % 16;
      if (m_state == 0) begin
        m_run = 0;
        m_state = 1;
      end else if (m_state == 1) begin
        if (value == pred) begin
          m_run++;
          if (m_run == 2) begin
            m_state = 2;
            m_locked = 1;
          end
        end else begin
          m_run = 0;
        end
      end else if (m_state == 2) begin
        if (value != pred) begin
          m_diff = 1;
          if (m_err == 0) begin
            m_got = value;
            m_expv = pred;
          end
          if (m_err < 255) m_err++;
          if (m_err >= 3) begin
            m_state = 3;
            m_locked = 0;
            m_fail = 1;
          end
        end
      end
      if (m_state != 3) m_prev = value;
    end
  endtask

  task automatic applyStimulus(input int rst, input int en, input int value);
    exp_t e;
    reset     = (rst != 0);
    sample_en = (en != 0);
    contador  = 4'(value);
    modelStep(rst, en, value);
    e.locked = m_locked; e.diff = m_diff; e.err = m_err;
    e.got = m_got; e.expv = m_expv; e.fail = m_fail;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    cycle_count++;
    e = sb_q.pop_front();
    checkOutput($sformatf("c%0d_locked", cycle_count), int'(locked), e.locked);
    checkOutput($sformatf("c%0d_diff_flag", cycle_count), int'(diff_flag), e.diff);
    checkOutput($sformatf("c%0d_err_count", cycle_count), int'(err_count), e.err);
    checkOutput($sformatf("c%0d_first_got", cycle_count), int'(first_err_got), e.got);
    checkOutput($sformatf("c%0d_first_exp", cycle_count), int'(first_err_exp), e.expv);
    checkOutput($sformatf("c%0d_fail", cycle_count), int'(fail), e.fail);
  endtask

  task automatic sampleSeq(input int vals[$]);
    foreach (vals[i]) applyStimulus(0, 1, vals[i]);
  endtask

  initial begin
    reset = 1'b1; sample_en = 1'b0; contador = '0;
    m_state = 0; m_prev = 0; m_run = 0; m_err = 0;
    m_got = 0; m_expv = 0; m_locked = 0; m_fail = 0; m_diff = 0;

    // Reset with a live sample on the same edges; sample must be discarded.
    applyStimulus(1, 1, 5);
    applyStimulus(1, 1, 5);
    checkOutput("rst_locked", int'(locked), 0);
    checkOutput("rst_err", int'(err_count), 0);
    checkOutput("rst_fail", int'(fail), 0);
    applyStimulus(0, 1, 5);
    checkOutput("first_sample_not_locked", int'(locked), 0);

    // Lock across the 15 -> 0 wrap.
    sampleSeq('{13, 14});
    checkOutput("pre_lock", int'(locked), 0);
    applyStimulus(0, 1, 15);
    checkOutput("lock_after_15", int'(locked), 1);
    sampleSeq('{0, 1});
    checkOutput("wrap_no_err", int'(err_count), 0);

    // Mismatch while locking is not an error.
    applyStimulus(1, 0, 0);
    sampleSeq('{2, 3, 7, 8});
    checkOutput("locking_no_lock_yet", int'(locked), 0);
    applyStimulus(0, 1, 9);
    checkOutput("lock_after_9", int'(locked), 1);
    checkOutput("locking_no_err", int'(err_count), 0);

    // Single glitch while locked.
    applyStimulus(1, 0, 0);
    sampleSeq('{1, 2, 3, 4, 9});
    checkOutput("glitch_diff", int'(diff_flag), 1);
    checkOutput("glitch_got", int'(first_err_got), 9);
    checkOutput("glitch_exp", int'(first_err_exp), 5);
    applyStimulus(0, 1, 10);
    checkOutput("glitch_recover", int'(diff_flag), 0);
    checkOutput("glitch_err1", int'(err_count), 1);

    // Back-to-back mismatches drive the monitor into FAIL.
    applyStimulus(1, 0, 0);
    sampleSeq('{2, 3, 4, 8, 12, 0});
    checkOutput("fail_err3", int'(err_count), 3);
    checkOutput("fail_flag", int'(fail), 1);
    checkOutput("fail_unlocked", int'(locked), 0);
    checkOutput("fail_got", int'(first_err_got), 8);
    checkOutput("fail_exp", int'(first_err_exp), 5);
    sampleSeq('{1, 7, 7, 2});
    checkOutput("fail_sticky_err", int'(err_count), 3);

    // Stuck counter never locks.
    applyStimulus(1, 0, 0);
    sampleSeq('{4, 4, 4, 4, 4});
    checkOutput("stuck_no_lock", int'(locked), 0);

    // sample_en gaps, then reset and relock.
    applyStimulus(1, 0, 0);
    sampleSeq('{5, 6, 7});
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 3);
    checkOutput("gap_still_locked", int'(locked), 1);
    applyStimulus(0, 1, 8);
    checkOutput("gap_resume_ok", int'(diff_flag), 0);
    applyStimulus(1, 0, 0);
    checkOutput("reset_unlocked", int'(locked), 0);
    sampleSeq('{0, 1, 2});
    checkOutput("relock", int'(locked), 1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/contador_monitor.md
Name: contador_monitor

Overview:
- Hardware receiver/checker for the 4-bit `contador` stream driven by the chip counter.
- Locks onto the incoming sequence and predicts each next value as previous + STEP, modulo 2^WIDTH.
- Flags deviations, counts them, and captures the first bad sample.
- Acts as the on-chip consumer of the counter output, giving a synthesizable equivalent of the bench-side model/checker pair.

Parameters:
- WIDTH, 4, width of the observed count.
- STEP, 1, expected increment per sample (mod 2^WIDTH).
- LOCK_CNT, 2, consecutive correct transitions required to declare lock (>=1).
- MAX_ERR, 3, error count at which the monitor enters FAIL; 0 disables FAIL.
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_en  in  1  contador is valid this cycle.
- contador  in  WIDTH  observed count value.
- locked  out  1  sequence tracking is established.
- diff_flag  out  1  one-cycle pulse: the last sample mismatched the prediction while locked.
- err_count  out  ERR_W  number of mismatches seen while locked; saturating.
- first_err_got  out  WIDTH  contador value of the first mismatch.
- first_err_exp  out  WIDTH  predicted value at the first mismatch.
- fail  out  1  sticky; err_count reached MAX_ERR.

Behaviour:
- Reset and timing:
  - Interface: one clock, `clk`; reset is synchronous and active-high, named `reset`.
  - Reset has priority over every other input.
  - Reset values: state = UNLOCKED; prev = 0; good_run = 0; all outputs = 0.
  - All outputs are registered. The effect of a sample is visible on the outputs the cycle after the edge that samples it (latency 1).
- Sample qualification:
  - Samples are taken only when sample_en = 1.
  - With sample_en = 0: state, prev, counters and captures all hold; diff_flag is 0.
- Prediction: exp = (prev + STEP) mod 2^WIDTH, computed as a WIDTH-bit truncating add. Example: 15 -> 0 is a correct transition for WIDTH = 4, STEP = 1.
- FSM:
  - UNLOCKED:
    - On a sample: prev <= contador; good_run <= 0; go to LOCKING.
  - LOCKING:
    - On a sample, prev <= contador.
    - If contador == exp: good_run++. When good_run reaches LOCK_CNT, go to LOCKED and set locked = 1.
    - If contador != exp: good_run <= 0; stay in LOCKING. No error is counted and diff_flag stays 0.
  - LOCKED:
    - On a sample, prev <= contador. Resynchronising to the observed value means a single glitch costs exactly one error.
    - Match: diff_flag = 0.
    - Mismatch, all of the following on the same edge:
      - diff_flag = 1 for exactly one cycle.
      - err_count++, saturating at 2^ERR_W - 1.
      - If err_count was 0, capture first_err_got = contador and first_err_exp = exp. These captures never update again until reset.
      - If MAX_ERR != 0 and the new err_count >= MAX_ERR: go to FAIL.
  - FAIL:
    - fail = 1, locked = 0.
    - diff_flag pulses for the mismatch that caused the entry, then stays 0.
    - All samples are ignored; err_count and captures hold.
    - The only exit is reset.
- Boundary conditions:
  - Back-to-back mismatches produce consecutive diff_flag pulses, one per sample.
  - Reset asserted on the same edge as a sample: reset wins and the sample is discarded.
  - Reset in any state returns to UNLOCKED; relocking then requires a fresh first sample plus LOCK_CNT good transitions.
  - A constant contador (stuck counter) with STEP != 0 never locks from UNLOCKED. Once LOCKED, it mismatches on every sample.

Test Plan (defaults: WIDTH = 4, STEP = 1, LOCK_CNT = 2, MAX_ERR = 3):
1. Reset held 2 cycles with sample_en = 1, contador = 5 -> locked, diff_flag, fail, err_count, first_err_* all 0; the first post-reset sample moves to LOCKING only.
2. Lock with wrap: samples 13, 14, 15, 0, 1 -> locked = 1 one cycle after sampling 15; the 15 -> 0 wrap gives diff_flag = 0 throughout; err_count = 0.
3. Mismatch during locking: samples 2, 3, 7, 8, 9 -> no diff_flag and err_count = 0; locked = 1 one cycle after sampling 9.
4. Single glitch while locked: samples 3, 4, 9, 10 ->
   - diff_flag is high exactly one cycle, after the 9 is sampled.
   - err_count = 1; first_err_got = 9; first_err_exp = 5.
   - The 10 is accepted and diff_flag returns to 0.
5. Fail path: while locked, samples 4, 8, 12, 0 ->
   - Three mismatches give err_count = 3, fail = 1, locked = 0.
   - first_err_* = 8/5, unchanged by later errors.
   - Further samples change nothing.
6. sample_en gaps and reset recovery:
   - Locked on 6, 7; hold sample_en = 0 for 5 cycles with contador = 3 -> no output change; sample 8 -> diff_flag = 0.
   - Then pulse reset for 1 cycle -> all outputs 0; samples 0, 1, 2 relock.
